// File: rtl/uart_txq_pkg.sv
// Shared types and sizing helpers for the UART transmit queue.
package uart_txq_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } txq_state_e;

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/uart_txq_fifo_mem.sv
// Byte storage for the transmit queue: circular buffer with read/write pointers and an occupancy count.
// Flush clears pointers and count and overrides any push or pop in the same cycle.
module uart_txq_fifo_mem
  import uart_txq_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic                      pop,
  input  logic                      flush,
  input  logic [BYTE_W-1:0]         wr_data,
  output logic [BYTE_W-1:0]         head,
  output logic [ptr_width(DEPTH):0] count,
  output logic                      empty,
  output logic                      full
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [BYTE_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

endmodule

// File: rtl/uart_tx_queue.sv
// Transmit queue in front of a UART: buffers producer bytes and launches one at a time with a start pulse.
// Define UART_TXQ_TIMEOUT_EN to abandon launches that are never acknowledged and raise sticky tx_err.
module uart_tx_queue
  import uart_txq_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_valid,
  input  logic [BYTE_W-1:0]         wr_data,
  output logic                      wr_ready,
  input  logic                      flush,
  output logic                      uart_start,
  output logic [BYTE_W-1:0]         uart_data,
  input  logic                      uart_ready_i,
  input  logic                      uart_busy_i,
  output logic [ptr_width(DEPTH):0] count,
  output logic                      empty,
  output logic                      full,
  output logic                      tx_err
);

  txq_state_e        state_q;
  txq_state_e        state_d;
  logic              start_d;
  logic [BYTE_W-1:0] data_d;
  logic [BYTE_W-1:0] head;
  logic              push;
  logic              pop;

  // Unsupported sizing leaves this marker block in the elaborated hierarchy.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || ACK_TIMEOUT < 2) begin : g_unsupported_params
  end

  assign wr_ready = !full;
  assign push     = wr_valid && wr_ready;

  uart_txq_fifo_mem #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .flush   (flush),
    .wr_data (wr_data),
    .head    (head),
    .count   (count),
    .empty   (empty),
    .full    (full)
  );

`ifdef UART_TXQ_TIMEOUT_EN
  localparam int TMR_W = ($clog2(ACK_TIMEOUT + 1) > 8) ? $clog2(ACK_TIMEOUT + 1) : 8;

  logic [TMR_W-1:0] timer_q;
  logic [TMR_W-1:0] timer_d;
  logic             tx_err_q;
  logic             tx_err_d;

  assign tx_err = tx_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q  <= '0;
      tx_err_q <= 1'b0;
    end else begin
      timer_q  <= timer_d;
      tx_err_q <= tx_err_d;
    end
  end
`else
  assign tx_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      uart_start <= 1'b0;
      uart_data  <= '0;
    end else begin
      state_q    <= state_d;
      uart_start <= start_d;
      uart_data  <= data_d;
    end
  end

  // A flush in IDLE blocks the launch so the popped byte and the cleared queue never disagree.
  always_comb begin
    state_d = state_q;
    start_d = 1'b0;
    data_d  = uart_data;
    pop     = 1'b0;
`ifdef UART_TXQ_TIMEOUT_EN
    timer_d  = timer_q;
    tx_err_d = tx_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (!empty && uart_ready_i && !flush) begin
          data_d  = head;
          start_d = 1'b1;
          pop     = 1'b1;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        state_d = WAIT_ACK;
`ifdef UART_TXQ_TIMEOUT_EN
        // The launch cycle itself counts toward the acknowledge window.
        timer_d = TMR_W'(1);
`endif
      end
      WAIT_ACK: begin
        if (uart_busy_i) begin
          state_d = WAIT_DONE;
`ifdef UART_TXQ_TIMEOUT_EN
        end else if (timer_q == TMR_W'(ACK_TIMEOUT - 1)) begin
          tx_err_d = 1'b1;
          state_d  = IDLE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
`endif
        end
      end
      WAIT_DONE: begin
        if (uart_ready_i && !uart_busy_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef UART_TXQ_TIMEOUT_EN
    if (flush) begin
      tx_err_d = 1'b0;
    end
`endif
  end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Self-checking bench for uart_tx_queue: directed scenarios plus random traffic against a queue-based scoreboard.
// The UART_TXQ_TIMEOUT_EN scenario runs only when the macro is defined for the build.
module tb_uart_tx_queue;

  localparam int DEPTH       = 16;
  localparam int ACK_TIMEOUT = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       flush = 1'b0;
  logic       uart_ready_i = 1'b1;
  logic       uart_busy_i = 1'b0;
  logic       wr_ready;
  logic       uart_start;
  logic [7:0] uart_data;
  logic [4:0] count;
  logic       empty;
  logic       full;
  logic       tx_err;

  int tests = 0;
  int fails = 0;

  logic [7:0] exp_q[$];
  logic [7:0] exp_b;
  logic [7:0] last_launched = 8'h00;
  logic       prev_start = 1'b0;
  logic       prev_ready = 1'b1;
  logic       prev_busy = 1'b0;
  int         start_count = 0;

  logic tx_hold = 1'b0;
  logic fixed_mode = 1'b1;
  logic no_ack = 1'b0;
  int   m_phase = 0;
  int   m_cnt = 0;

  always #5 clk = ~clk;

  uart_tx_queue #(
    .DEPTH       (DEPTH),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_valid     (wr_valid),
    .wr_data      (wr_data),
    .wr_ready     (wr_ready),
    .flush        (flush),
    .uart_start   (uart_start),
    .uart_data    (uart_data),
    .uart_ready_i (uart_ready_i),
    .uart_busy_i  (uart_busy_i),
    .count        (count),
    .empty        (empty),
    .full         (full),
    .tx_err       (tx_err)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one cycle of producer inputs; entered and left 2ns after a rising edge.
  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic f);
    wr_valid = v;
    wr_data  = d;
    flush    = f;
    @(posedge clk);
    #2;
    wr_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic waitStart(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!uart_start && n < 200);
    checkOutput({name, "_start_seen"}, {31'b0, uart_start}, 32'd1);
  endtask

  task automatic waitDrain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_phase != 0 || uart_ready_i !== 1'b1) && n < 3000) begin
      @(posedge clk);
      #2;
      n++;
    end
    repeat (4) begin
      @(posedge clk);
      #2;
    end
    checkOutput({name, "_drained"}, {31'b0, (n < 3000)}, 32'd1);
  endtask

  // Transmitter model: acknowledges each start with busy after a delay, then returns to ready.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      m_phase      = 0;
      uart_ready_i = 1'b1;
      uart_busy_i  = 1'b0;
    end else begin
      case (m_phase)
        0: begin
          if (uart_start) begin
            m_cnt   = fixed_mode ? 1 : int'($urandom_range(0, 3));
            m_phase = no_ack ? 0 : 1;
          end else if (tx_hold) begin
            uart_ready_i = 1'b0;
            uart_busy_i  = 1'b1;
          end else begin
            uart_ready_i = 1'b1;
            uart_busy_i  = 1'b0;
          end
        end
        1: begin
          if (m_cnt == 0) begin
            uart_busy_i  = 1'b1;
            uart_ready_i = 1'b0;
            m_cnt        = fixed_mode ? 8 : int'($urandom_range(1, 6));
            m_phase      = 2;
          end else m_cnt--;
        end
        2: begin
          if (m_cnt == 0) begin
            uart_busy_i = 1'b0;
            m_cnt       = fixed_mode ? 1 : int'($urandom_range(0, 2));
            m_phase     = 3;
          end else m_cnt--;
        end
        default: begin
          if (m_cnt == 0) begin
            uart_ready_i = 1'b1;
            m_phase      = 0;
          end else m_cnt--;
        end
      endcase
    end
  end

  // Scoreboard monitor: checks the cycle just seen, then records what the coming edge will accept.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      last_launched = 8'h00;
    end else begin
      if (uart_start) begin
        start_count++;
        checkOutput("launch_when_ready", {31'b0, prev_ready}, 32'd1);
        checkOutput("launch_while_busy", {31'b0, prev_busy}, 32'd0);
        checkOutput("start_single_cycle", {31'b0, prev_start}, 32'd0);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL unexpected_start: got data 0x%0h, expected no launch at %0t", uart_data, $time);
        end else begin
          exp_b = exp_q.pop_front();
          checkOutput("launch_data", {24'b0, uart_data}, {24'b0, exp_b});
          last_launched = exp_b;
        end
      end else begin
        checkOutput("uart_data_hold", {24'b0, uart_data}, {24'b0, last_launched});
      end
      checkOutput("count", {27'b0, count}, exp_q.size());
      checkOutput("empty", {31'b0, empty}, {31'b0, (exp_q.size() == 0)});
      checkOutput("full", {31'b0, full}, {31'b0, (exp_q.size() == DEPTH)});
      checkOutput("wr_ready", {31'b0, wr_ready}, {31'b0, (exp_q.size() != DEPTH)});
`ifndef UART_TXQ_TIMEOUT_EN
      checkOutput("tx_err_tied", {31'b0, tx_err}, 32'd0);
`endif
      if (flush) exp_q.delete();
      else if (wr_valid && exp_q.size() < DEPTH) exp_q.push_back(wr_data);
    end
    prev_start = uart_start;
    prev_ready = uart_ready_i;
    prev_busy  = uart_busy_i;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int s0;
    int n;

    rst = 1'b1;
    #1;
    checkOutput("rst_count", {27'b0, count}, 32'd0);
    checkOutput("rst_empty", {31'b0, empty}, 32'd1);
    checkOutput("rst_full", {31'b0, full}, 32'd0);
    checkOutput("rst_wr_ready", {31'b0, wr_ready}, 32'd1);
    checkOutput("rst_uart_start", {31'b0, uart_start}, 32'd0);
    checkOutput("rst_uart_data", {24'b0, uart_data}, 32'd0);
    checkOutput("rst_tx_err", {31'b0, tx_err}, 32'd0);
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #2;

    // Single byte: start must be high exactly in the cycle after the second edge.
    applyStimulus(1'b1, 8'hA5, 1'b0);
    @(negedge clk);
    checkOutput("lat_before", {31'b0, uart_start}, 32'd0);
    @(negedge clk);
    checkOutput("lat_start", {31'b0, uart_start}, 32'd1);
    checkOutput("lat_data", {24'b0, uart_data}, 32'hA5);
    @(negedge clk);
    checkOutput("lat_after", {31'b0, uart_start}, 32'd0);
    checkOutput("lat_count", {27'b0, count}, 32'd0);
    @(posedge clk);
    #2;
    waitDrain("single");

    // Burst to full while the transmitter is busy, then drain in order.
    tx_hold = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0);
    s0 = start_count;
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 8'(i), 1'b0);
    @(negedge clk);
    checkOutput("burst_wr_ready", {31'b0, wr_ready}, 32'd0);
    checkOutput("burst_full", {31'b0, full}, 32'd1);
    checkOutput("burst_count", {27'b0, count}, 32'd16);
    @(posedge clk);
    #2;
    applyStimulus(1'b1, 8'h10, 1'b0);
    @(negedge clk);
    checkOutput("burst_17th_rejected", {27'b0, count}, 32'd16);
    @(posedge clk);
    #2;
    tx_hold = 1'b0;
    waitDrain("burst");
    checkOutput("burst_starts", start_count - s0, 32'd16);

    // Push in the launch cycle with three bytes queued: count stays at three.
    tx_hold = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0);
    applyStimulus(1'b1, 8'h30, 1'b0);
    applyStimulus(1'b1, 8'h31, 1'b0);
    applyStimulus(1'b1, 8'h32, 1'b0);
    tx_hold = 1'b0;
    @(posedge clk);
    #2;
    applyStimulus(1'b1, 8'h33, 1'b0);
    @(negedge clk);
    checkOutput("simul_start", {31'b0, uart_start}, 32'd1);
    checkOutput("simul_count", {27'b0, count}, 32'd3);
    @(posedge clk);
    #2;
    waitDrain("simul");

    // Flush while the first byte is shifting: it completes, nothing else launches.
    tx_hold = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0);
    applyStimulus(1'b1, 8'h11, 1'b0);
    applyStimulus(1'b1, 8'h22, 1'b0);
    applyStimulus(1'b1, 8'h33, 1'b0);
    tx_hold = 1'b0;
    waitStart("flush");
    n = 0;
    while (!uart_busy_i && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    @(posedge clk);
    #2;
    s0 = start_count;
    applyStimulus(1'b0, 8'h00, 1'b1);
    @(negedge clk);
    checkOutput("flush_count", {27'b0, count}, 32'd0);
    @(posedge clk);
    #2;
    waitDrain("flush");
    repeat (20) @(posedge clk);
    #2;
    checkOutput("flush_no_launch", start_count - s0, 32'd0);

    // Asynchronous reset while waiting for the acknowledge.
    tx_hold = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0);
    applyStimulus(1'b1, 8'h41, 1'b0);
    applyStimulus(1'b1, 8'h42, 1'b0);
    applyStimulus(1'b1, 8'h43, 1'b0);
    tx_hold = 1'b0;
    waitStart("rstmid");
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rstmid_count", {27'b0, count}, 32'd0);
    checkOutput("rstmid_empty", {31'b0, empty}, 32'd1);
    checkOutput("rstmid_full", {31'b0, full}, 32'd0);
    checkOutput("rstmid_wr_ready", {31'b0, wr_ready}, 32'd1);
    checkOutput("rstmid_uart_start", {31'b0, uart_start}, 32'd0);
    checkOutput("rstmid_uart_data", {24'b0, uart_data}, 32'd0);
    checkOutput("rstmid_tx_err", {31'b0, tx_err}, 32'd0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #2;
    applyStimulus(1'b1, 8'h5A, 1'b0);
    waitStart("after_rst");
    checkOutput("after_rst_data", {24'b0, uart_data}, 32'h5A);
    @(posedge clk);
    #2;
    waitDrain("after_rst");

    // Random traffic with random transmitter timing and occasional flushes.
    fixed_mode = 1'b0;
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 49) == 0));
    end
    waitDrain("random");
    fixed_mode = 1'b1;

`ifdef UART_TXQ_TIMEOUT_EN
    // Launch never acknowledged: tx_err rises ACK_TIMEOUT cycles after the start pulse.
    no_ack = 1'b1;
    applyStimulus(1'b1, 8'h77, 1'b0);
    waitStart("timeout");
    n = 0;
    while (!tx_err && n < ACK_TIMEOUT + 10) begin
      @(negedge clk);
      n++;
    end
    checkOutput("timeout_cycles", n, ACK_TIMEOUT);
    checkOutput("timeout_tx_err", {31'b0, tx_err}, 32'd1);
    no_ack = 1'b0;
    @(posedge clk);
    #2;
    applyStimulus(1'b1, 8'h78, 1'b0);
    waitDrain("timeout_next");
    checkOutput("timeout_sticky", {31'b0, tx_err}, 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b1);
    @(negedge clk);
    checkOutput("timeout_flush_clear", {31'b0, tx_err}, 32'd0);
    @(posedge clk);
    #2;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
